// File: rtl/inst_axi_rd_bridge_if.sv
// Bundles the IF-side SRAM-like handshake and the AXI3 read channel of the instruction bridge.
// The bridge uses the slave view; whatever drives IF requests and plays the interconnect uses master.
interface inst_axi_rd_bridge_if;
  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;

  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;

  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport slave (
    input  inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_addr,
           inst_sram_wdata,
    output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport master (
    output inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_addr,
           inst_sram_wdata,
    input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/inst_axi_rd_bridge.sv
// SRAM-like instruction fetch handshake to single-beat, single-ID AXI3 reads.
// One AR slot, in-order responses, up to MAX_OUTST reads accepted but unanswered.
module inst_axi_rd_bridge #(
  parameter int unsigned MAX_OUTST = 2,
  parameter logic [3:0]  AR_ID     = 4'h0
) (
  input  logic                     clk,
  input  logic                     resetn,
  inst_axi_rd_bridge_if.slave      bus,
  output logic                     bus_err,
  output logic                     unexp_r
);

  logic        arvalid_q, arvalid_d;
  logic [31:0] araddr_q, araddr_d;
  logic [1:0]  size_q, size_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        bus_err_q, bus_err_d;
  logic        unexp_q, unexp_d;

  logic        r_hs;
  logic        cnt_nz;
  logic        rsp_take;
  logic [2:0]  cnt_eff;
  logic        ar_free;
  logic        addr_ok;

  assign r_hs     = bus.rvalid & bus.rready;
  assign cnt_nz   = (cnt_q != 3'd0);
  assign rsp_take = r_hs & cnt_nz;
  // A response retiring this cycle frees a credit for a request in the same cycle.
  assign cnt_eff  = cnt_q - {2'b00, rsp_take};
  assign ar_free  = ~arvalid_q | bus.arready;
  assign addr_ok  = resetn & bus.inst_sram_req & ar_free & (cnt_eff < 3'(MAX_OUTST));

  always_comb begin
    arvalid_d = arvalid_q;
    araddr_d  = araddr_q;
    size_d    = size_q;
    if (addr_ok) begin
      arvalid_d = 1'b1;
      araddr_d  = bus.inst_sram_addr;
      size_d    = bus.inst_sram_size;
    end else if (arvalid_q && bus.arready) begin
      arvalid_d = 1'b0;
    end

    cnt_d = cnt_q;
    case ({addr_ok, rsp_take})
      2'b10:   cnt_d = cnt_q + 3'd1;
      2'b01:   cnt_d = cnt_q - 3'd1;
      default: cnt_d = cnt_q;
    endcase

    bus_err_d = bus_err_q | (r_hs & (bus.rresp != 2'b00));
    unexp_d   = unexp_q | (r_hs & ~cnt_nz);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      arvalid_q <= 1'b0;
      araddr_q  <= 32'h0;
      size_q    <= 2'b00;
      cnt_q     <= 3'd0;
      bus_err_q <= 1'b0;
      unexp_q   <= 1'b0;
    end else begin
      arvalid_q <= arvalid_d;
      araddr_q  <= araddr_d;
      size_q    <= size_d;
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
      unexp_q   <= unexp_d;
    end
  end

  assign bus.inst_sram_addr_ok = addr_ok;
  assign bus.inst_sram_data_ok = rsp_take;
  assign bus.inst_sram_rdata   = bus.rdata;

  assign bus.arid    = AR_ID;
  assign bus.araddr  = araddr_q;
  assign bus.arlen   = 8'h00;
  assign bus.arsize  = {1'b0, size_q};
  assign bus.arburst = 2'b01;
  assign bus.arlock  = 2'b00;
  assign bus.arcache = 4'h0;
  assign bus.arprot  = 3'b000;
  assign bus.arvalid = arvalid_q;
  assign bus.rready  = resetn;

  assign bus_err = bus_err_q;
  assign unexp_r = unexp_q;

  // Write-side fields, RID and RLAST carry no information for single-ID single-beat reads.
  logic unused_inputs;
  assign unused_inputs = ^{bus.inst_sram_wr, bus.inst_sram_wstrb, bus.inst_sram_wdata,
                           bus.rid, bus.rlast};

endmodule

// File: tb/tb_inst_axi_rd_bridge.sv
// Bench for inst_axi_rd_bridge: a directed vector table, hand-written corner sequences and
// random traffic, all checked against a queue-based model of accepted and pending reads.
module tb_inst_axi_rd_bridge;
  localparam int MAX = 2;

  logic clk = 1'b0;
  logic resetn;
  logic bus_err, unexp_r;

  always #5 clk = ~clk;

  inst_axi_rd_bridge_if bus ();

  inst_axi_rd_bridge #(
    .MAX_OUTST (MAX),
    .AR_ID     (4'h0)
  ) dut (
    .clk     (clk),
    .resetn  (resetn),
    .bus     (bus),
    .bus_err (bus_err),
    .unexp_r (unexp_r)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Model: AR requests not yet handed to the interconnect, and count of unanswered reads.
  logic [33:0] ar_q[$];
  int          m_cnt;
  bit          m_berr, m_unexp;

  // Values sampled by the last cycle, for sequence-specific checks.
  logic        s_aok, s_dok, s_arv;
  logic [31:0] s_araddr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_clear();
    ar_q.delete();
    m_cnt   = 0;
    m_berr  = 1'b0;
    m_unexp = 1'b0;
  endtask

  task automatic set_idle();
    bus.inst_sram_req   = 1'b0;
    bus.inst_sram_wr    = 1'b0;
    bus.inst_sram_size  = 2'b10;
    bus.inst_sram_wstrb = 4'h0;
    bus.inst_sram_addr  = 32'h0;
    bus.inst_sram_wdata = 32'h0;
    bus.arready         = 1'b0;
    bus.rid             = 4'h0;
    bus.rdata           = 32'h0;
    bus.rresp           = 2'b00;
    bus.rlast           = 1'b1;
    bus.rvalid          = 1'b0;
  endtask

  task automatic do_reset(input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      resetn = 1'b0;
      set_idle();
      #2;
      chk("rready_in_reset", bus.rready, 1'b0);
    end
    model_clear();
  endtask

  // One clock with the given inputs; every output is checked against the model.
  task automatic cyc(input logic req, input logic [31:0] addr, input logic [1:0] size,
                     input logic ardy, input logic rv, input logic [31:0] rd,
                     input logic [1:0] rr);
    bit dec, free, exp_aok;
    @(negedge clk);
    resetn              = 1'b1;
    bus.inst_sram_req   = req;
    bus.inst_sram_addr  = addr;
    bus.inst_sram_size  = size;
    bus.inst_sram_wr    = 1'($urandom_range(0, 1));
    bus.inst_sram_wdata = $urandom;
    bus.arready         = ardy;
    bus.rvalid          = rv;
    bus.rdata           = rd;
    bus.rresp           = rr;
    #2;
    dec     = rv && (m_cnt > 0);
    free    = (ar_q.size() == 0) || ardy;
    exp_aok = req && free && ((m_cnt - int'(dec)) < MAX);

    s_aok    = bus.inst_sram_addr_ok;
    s_dok    = bus.inst_sram_data_ok;
    s_arv    = bus.arvalid;
    s_araddr = bus.araddr;

    chk("addr_ok", bus.inst_sram_addr_ok, exp_aok);
    chk("data_ok", bus.inst_sram_data_ok, dec);
    if (dec) chk("inst_rdata", bus.inst_sram_rdata, rd);
    chk("arvalid", bus.arvalid, ar_q.size() != 0);
    if (ar_q.size() != 0) begin
      chk("araddr", bus.araddr, ar_q[0][31:0]);
      chk("arsize", bus.arsize, {1'b0, ar_q[0][33:32]});
      chk("ar_fixed", {bus.arid, bus.arlen, bus.arburst, bus.arlock, bus.arcache, bus.arprot},
          {4'h0, 8'h00, 2'b01, 2'b00, 4'h0, 3'b000});
    end
    chk("rready", bus.rready, 1'b1);
    chk("bus_err", bus_err, m_berr);
    chk("unexp_r", unexp_r, m_unexp);

    if (ar_q.size() != 0 && ardy) void'(ar_q.pop_front());
    if (exp_aok) begin
      ar_q.push_back({size, addr});
      m_cnt++;
    end
    if (dec) m_cnt--;
    if (rv && !dec) m_unexp = 1'b1;
    if (rv && rr != 2'b00) m_berr = 1'b1;
    if (m_cnt > MAX) chk("model_cnt_bound", 64'(m_cnt), 64'(MAX));
  endtask

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic        ardy;
    logic        rv;
    logic [31:0] rd;
    logic        e_aok;
    logic        e_arv;
    logic [31:0] e_araddr;
    logic        e_dok;
  } vec_t;

  vec_t vecs[13];

  initial begin
    // Single read, then the outstanding limit with req held and arready high.
    vecs[0]  = '{1, 32'h1c000000, 0, 0, 32'h0,        1, 0, 32'h0,        0};
    vecs[1]  = '{0, 32'h0,        1, 0, 32'h0,        0, 1, 32'h1c000000, 0};
    vecs[2]  = '{0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0,        0};
    vecs[3]  = '{0, 32'h0,        0, 1, 32'h02800c0c, 0, 0, 32'h0,        1};
    vecs[4]  = '{0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0,        0};
    vecs[5]  = '{1, 32'h1c000004, 1, 0, 32'h0,        1, 0, 32'h0,        0};
    vecs[6]  = '{1, 32'h1c000008, 1, 0, 32'h0,        1, 1, 32'h1c000004, 0};
    vecs[7]  = '{1, 32'h1c00000c, 1, 0, 32'h0,        0, 1, 32'h1c000008, 0};
    vecs[8]  = '{1, 32'h1c00000c, 1, 0, 32'h0,        0, 0, 32'h0,        0};
    vecs[9]  = '{1, 32'h1c00000c, 1, 1, 32'h11111111, 1, 0, 32'h0,        1};
    vecs[10] = '{0, 32'h0,        1, 1, 32'h22222222, 0, 1, 32'h1c00000c, 1};
    vecs[11] = '{0, 32'h0,        1, 1, 32'h33333333, 0, 0, 32'h0,        1};
    vecs[12] = '{0, 32'h0,        1, 0, 32'h0,        0, 0, 32'h0,        0};

    resetn = 1'b0;
    set_idle();
    model_clear();
    do_reset(2);

    for (int i = 0; i < 13; i++) begin
      cyc(vecs[i].req, vecs[i].addr, 2'b10, vecs[i].ardy, vecs[i].rv, vecs[i].rd, 2'b00);
      chk($sformatf("vec%0d_addr_ok", i), s_aok, vecs[i].e_aok);
      chk($sformatf("vec%0d_arvalid", i), s_arv, vecs[i].e_arv);
      chk($sformatf("vec%0d_data_ok", i), s_dok, vecs[i].e_dok);
      if (vecs[i].e_arv) chk($sformatf("vec%0d_araddr", i), s_araddr, vecs[i].e_araddr);
    end

    // Backpressure: AR held for 5 cycles with a competing request.
    cyc(1, 32'h1c000100, 2'b10, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 32'h1c000200, 2'b10, 0, 0, 0, 0);
      chk("bp_arvalid_held", s_arv, 1'b1);
      chk("bp_araddr_stable", s_araddr, 32'h1c000100);
      chk("bp_no_addr_ok", s_aok, 1'b0);
    end
    cyc(1, 32'h1c000200, 2'b10, 1, 0, 0, 0);
    chk("bp_reload_addr_ok", s_aok, 1'b1);
    cyc(0, 0, 2'b10, 1, 0, 0, 0);
    chk("bp_back_to_back_arvalid", s_arv, 1'b1);
    chk("bp_back_to_back_araddr", s_araddr, 32'h1c000200);
    cyc(0, 0, 2'b10, 0, 1, 32'haaaa0001, 0);

    // Simultaneous accept and response with one read outstanding.
    cyc(1, 32'h1c000300, 2'b10, 1, 1, 32'haaaa0002, 0);
    chk("sim_addr_ok", s_aok, 1'b1);
    chk("sim_data_ok", s_dok, 1'b1);
    cyc(0, 0, 2'b10, 1, 0, 0, 0);
    cyc(0, 0, 2'b10, 0, 1, 32'hdead0000, 2'b10);
    chk("err_data_ok", s_dok, 1'b1);
    cyc(0, 0, 2'b10, 0, 0, 0, 0);
    chk("bus_err_set", bus_err, 1'b1);

    // Stray beat with nothing outstanding.
    cyc(0, 0, 2'b10, 0, 1, 32'hbeef0000, 0);
    chk("unexp_no_data_ok", s_dok, 1'b0);
    cyc(0, 0, 2'b10, 0, 0, 0, 0);
    chk("unexp_set", unexp_r, 1'b1);
    chk("bus_err_sticky", bus_err, 1'b1);

    // Reset with two reads in flight and AR valid.
    cyc(1, 32'h1c000400, 2'b10, 0, 0, 0, 0);
    cyc(1, 32'h1c000500, 2'b10, 1, 0, 0, 0);
    chk("pre_reset_cnt", 64'(m_cnt), 64'd2);
    do_reset(1);
    cyc(1, 32'h1c000600, 2'b10, 0, 0, 0, 0);
    chk("post_reset_arvalid", s_arv, 1'b0);
    chk("post_reset_addr_ok", s_aok, 1'b1);
    chk("post_reset_flags", {bus_err, unexp_r}, 2'b00);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      logic rv;
      if ($urandom_range(0, 299) == 0) begin
        do_reset(1);
      end else begin
        rv = (m_cnt > 0) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 99) < 3);
        cyc($urandom_range(0, 9) < 6, {$urandom_range(0, 32'h3fffffff), 2'b00},
            2'($urandom_range(0, 3)), $urandom_range(0, 1) == 1, rv, $urandom,
            ($urandom_range(0, 19) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
